// File: rtl/pipe_control.sv
// Decode and hazard control for a three-stage EX/MEM/WB pipeline. Generates per-stage control
// words and stalls on load-use and multiplier-occupancy hazards.
module pipe_control #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned MUL_LAT    = 2,
  parameter int unsigned CNT_W      = 8,
  localparam int unsigned CW        = 9 + 3 * REG_ADDR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  input  logic [31:0]      instruction,
  output logic             instr_ready,
  output logic [CW-1:0]    ctrl_ex,
  output logic             valid_ex,
  output logic [CW-1:0]    ctrl_mem,
  output logic             valid_mem,
  output logic [CW-1:0]    ctrl_wb,
  output logic             valid_wb,
  output logic             illegal,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam int unsigned A      = REG_ADDR_W;
  localparam int unsigned BUSY_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam int unsigned RW_B   = CW - 1;
  localparam int unsigned MWB_B  = 3 * A + 2;

  logic [5:0]        w_opcode;
  logic [4:0]        w_shamt;
  logic [5:0]        w_funct;
  logic [A-1:0]      w_rs, w_rt, w_rd_field, w_rd;
  logic              w_rw, w_eo, w_mai, w_mao, w_mwb, w_wr, w_hab;
  logic [1:0]        w_alu;
  logic              w_legal, w_is_mul, w_rtype, w_sw;
  logic [CW-1:0]     w_word;
  logic              w_load_use, w_mul_haz, w_stall, w_accept;

  logic [CW-1:0]     r_ctrl_ex, r_ctrl_mem, r_ctrl_wb;
  logic              r_valid_ex, r_valid_mem, r_valid_wb;
  logic              r_illegal;
  logic [CNT_W-1:0]  r_illegal_cnt;
  logic [BUSY_W-1:0] r_mul_busy;

  assign w_opcode   = instruction[31:26];
  assign w_shamt    = instruction[10:6];
  assign w_funct    = instruction[5:0];
  assign w_rs       = A'(instruction[25:21]);
  assign w_rt       = A'(instruction[20:16]);
  assign w_rd_field = A'(instruction[15:11]);
  assign w_rtype    = (w_opcode == 6'd7) && (w_shamt == 5'd10);
  assign w_sw       = (w_opcode == 6'd9);

  always_comb begin
    w_rw     = 1'b0;
    w_alu    = 2'd0;
    w_eo     = 1'b0;
    w_mai    = 1'b0;
    w_mao    = 1'b0;
    w_mwb    = 1'b0;
    w_wr     = 1'b0;
    w_hab    = 1'b0;
    w_rd     = '0;
    w_legal  = 1'b0;
    w_is_mul = 1'b0;
    case (w_opcode)
      6'd8: begin
        w_legal = 1'b1;
        w_rw    = 1'b1;
        w_eo    = 1'b1;
        w_mai   = 1'b1;
        w_mao   = 1'b1;
        w_mwb   = 1'b1;
        w_rd    = w_rt;
      end
      6'd9: begin
        w_legal = 1'b1;
        w_eo    = 1'b1;
        w_mai   = 1'b1;
        w_mao   = 1'b1;
        w_mwb   = 1'b1;
        w_wr    = 1'b1;
      end
      6'd7: begin
        if (w_rtype) begin
          case (w_funct)
            6'd32, 6'd34, 6'd36, 6'd37: begin
              w_legal = 1'b1;
              w_rw    = 1'b1;
              w_mao   = 1'b1;
              w_rd    = w_rd_field;
              w_alu   = (w_funct == 6'd32) ? 2'd0 :
                        (w_funct == 6'd34) ? 2'd1 :
                        (w_funct == 6'd36) ? 2'd2 : 2'd3;
            end
            6'd50: begin
              w_legal  = 1'b1;
              w_is_mul = 1'b1;
              w_rw     = 1'b1;
              w_hab    = 1'b1;
              w_rd     = w_rd_field;
            end
            default: ;
          endcase
        end
      end
      default: ;
    endcase
  end

  assign w_word = {w_rw, w_alu, w_eo, w_mai, w_mao, w_mwb, w_wr, w_hab, w_rs, w_rt, w_rd};

  // Only a load (MUX_WB && RW) in EX can produce a value not yet available to the next decode
  assign w_load_use = r_valid_ex && r_ctrl_ex[MWB_B] && r_ctrl_ex[RW_B] &&
                      (r_ctrl_ex[A-1:0] != '0) &&
                      ((r_ctrl_ex[A-1:0] == w_rs) ||
                       ((r_ctrl_ex[A-1:0] == w_rt) && (w_rtype || w_sw)));
  assign w_mul_haz  = w_is_mul && (r_mul_busy != '0);
  assign w_stall    = instr_valid && (w_load_use || w_mul_haz);
  assign w_accept   = instr_valid && !w_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ctrl_ex   <= '0;
      r_ctrl_mem  <= '0;
      r_ctrl_wb   <= '0;
      r_valid_ex  <= 1'b0;
      r_valid_mem <= 1'b0;
      r_valid_wb  <= 1'b0;
    end else begin
      r_ctrl_wb   <= r_ctrl_mem;
      r_valid_wb  <= r_valid_mem;
      r_ctrl_mem  <= r_ctrl_ex;
      r_valid_mem <= r_valid_ex;
      if (w_accept && w_legal) begin
        r_ctrl_ex  <= w_word;
        r_valid_ex <= 1'b1;
      end else begin
        r_ctrl_ex  <= '0;
        r_valid_ex <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_illegal     <= 1'b0;
      r_illegal_cnt <= '0;
      r_mul_busy    <= '0;
    end else begin
      r_illegal <= w_accept && !w_legal;
      if (w_accept && !w_legal && (r_illegal_cnt != '1)) begin
        r_illegal_cnt <= r_illegal_cnt + CNT_W'(1);
      end
      if (w_accept && w_is_mul) begin
        r_mul_busy <= BUSY_W'(MUL_LAT - 1);
      end else if (r_mul_busy != '0) begin
        r_mul_busy <= r_mul_busy - BUSY_W'(1);
      end
    end
  end

  assign instr_ready = !w_stall;
  assign ctrl_ex     = r_ctrl_ex;
  assign valid_ex    = r_valid_ex;
  assign ctrl_mem    = r_ctrl_mem;
  assign valid_mem   = r_valid_mem;
  assign ctrl_wb     = r_ctrl_wb;
  assign valid_wb    = r_valid_wb;
  assign illegal     = r_illegal;
  assign illegal_cnt = r_illegal_cnt;

endmodule

// File: tb/tb_pipe_control.sv
// Self-checking bench for pipe_control: directed hazard/illegal/reset scenarios followed by
// random traffic compared against an instruction-history reference model.
module tb_pipe_control;

  localparam int unsigned AW   = 5;
  localparam int unsigned LAT  = 3;
  localparam int unsigned CNTW = 8;
  localparam int unsigned CW   = 9 + 3 * AW;
  localparam int unsigned ALU_LO = CW - 3;
  localparam int unsigned HAB_B  = 3 * AW;
  localparam int unsigned MAO_B  = 3 * AW + 3;

  logic            clk = 1'b0;
  logic            rst;
  logic            instr_valid;
  logic [31:0]     instruction;
  logic            instr_ready;
  logic [CW-1:0]   ctrl_ex, ctrl_mem, ctrl_wb;
  logic            valid_ex, valid_mem, valid_wb;
  logic            illegal;
  logic [CNTW-1:0] illegal_cnt;

  pipe_control #(
    .REG_ADDR_W(AW),
    .MUL_LAT   (LAT),
    .CNT_W     (CNTW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .instr_valid(instr_valid),
    .instruction(instruction),
    .instr_ready(instr_ready),
    .ctrl_ex    (ctrl_ex),
    .valid_ex   (valid_ex),
    .ctrl_mem   (ctrl_mem),
    .valid_mem  (valid_mem),
    .ctrl_wb    (ctrl_wb),
    .valid_wb   (valid_wb),
    .illegal    (illegal),
    .illegal_cnt(illegal_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: expected stage contents plus instruction history
  logic [CW-1:0] m_ex, m_mem, m_wb;
  logic          m_vex, m_vmem, m_vwb, m_ill;
  int            m_cnt, m_cycle, m_last_mul, m_lw_dest;

  function automatic logic [31:0] enc_i(input int op, input int rs, input int rt);
    return {op[5:0], rs[4:0], rt[4:0], 16'h1234};
  endfunction

  function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd,
                                        input int funct, input int shamt);
    return {6'd7, rs[4:0], rt[4:0], rd[4:0], shamt[4:0], funct[5:0]};
  endfunction

  function automatic void ref_decode(input logic [31:0] ins, output logic legal,
                                     output logic is_mul, output logic rt_src,
                                     output logic [CW-1:0] word);
    int op, rs, rt, rdf, sh, fn;
    int rw, alu, eo, mai, mao, mwb, wr, hm, rd;
    op = int'(ins[31:26]); rs = int'(ins[25:21]); rt = int'(ins[20:16]);
    rdf = int'(ins[15:11]); sh = int'(ins[10:6]); fn = int'(ins[5:0]);
    rw = 0; alu = 0; eo = 0; mai = 0; mao = 0; mwb = 0; wr = 0; hm = 0; rd = 0;
    legal = 1'b0; is_mul = 1'b0;
    rt_src = (op == 9) || (op == 7 && sh == 10);
    if (op == 8) begin
      legal = 1'b1; rw = 1; eo = 1; mai = 1; mao = 1; mwb = 1; rd = rt;
    end else if (op == 9) begin
      legal = 1'b1; eo = 1; mai = 1; mao = 1; mwb = 1; wr = 1;
    end else if (op == 7 && sh == 10) begin
      if (fn == 32 || fn == 34 || fn == 36 || fn == 37) begin
        legal = 1'b1; rw = 1; mao = 1; rd = rdf;
        alu = (fn == 32) ? 0 : (fn == 34) ? 1 : (fn == 36) ? 2 : 3;
      end else if (fn == 50) begin
        legal = 1'b1; is_mul = 1'b1; rw = 1; hm = 1; rd = rdf;
      end
    end
    word = {rw[0], alu[1:0], eo[0], mai[0], mao[0], mwb[0], wr[0], hm[0],
            rs[4:0], rt[4:0], rd[4:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ex = '0; m_mem = '0; m_wb = '0;
    m_vex = 1'b0; m_vmem = 1'b0; m_vwb = 1'b0; m_ill = 1'b0;
    m_cnt = 0; m_cycle = 0; m_last_mul = -1000; m_lw_dest = -1;
  endtask

  task automatic check_outputs();
    check("ctrl_ex", 64'(ctrl_ex), 64'(m_ex));
    check("valid_ex", 64'(valid_ex), 64'(m_vex));
    check("ctrl_mem", 64'(ctrl_mem), 64'(m_mem));
    check("valid_mem", 64'(valid_mem), 64'(m_vmem));
    check("ctrl_wb", 64'(ctrl_wb), 64'(m_wb));
    check("valid_wb", 64'(valid_wb), 64'(m_vwb));
    check("illegal", 64'(illegal), 64'(m_ill));
    check("illegal_cnt", 64'(illegal_cnt), 64'(m_cnt));
  endtask

  // Entered and left 1 time unit after a rising edge
  task automatic step(input logic v, input logic [31:0] ins, output logic acc);
    logic legal, is_mul, rt_src, ld, mh, exp_ready;
    logic [CW-1:0] word;
    int rs, rt;
    instr_valid = v;
    instruction = ins;
    #1;
    ref_decode(ins, legal, is_mul, rt_src, word);
    rs = int'(ins[25:21]);
    rt = int'(ins[20:16]);
    ld = (m_lw_dest > 0) && ((rs == m_lw_dest) || (rt_src && rt == m_lw_dest));
    mh = is_mul && ((m_cycle - m_last_mul) < int'(LAT));
    exp_ready = !(v && (ld || mh));
    check("instr_ready", 64'(instr_ready), 64'(exp_ready));
    acc = v && exp_ready;
    @(posedge clk);
    m_wb = m_mem; m_vwb = m_vmem;
    m_mem = m_ex; m_vmem = m_vex;
    if (acc && legal) begin
      m_ex = word; m_vex = 1'b1;
    end else begin
      m_ex = '0; m_vex = 1'b0;
    end
    m_ill = acc && !legal;
    if (m_ill && m_cnt < 255) m_cnt++;
    m_lw_dest = (acc && legal && ins[31:26] == 6'd8) ? rt : -1;
    if (acc && is_mul) m_last_mul = m_cycle;
    m_cycle++;
    #1;
    check_outputs();
  endtask

  // Source holds the instruction until accepted; returns the number of stalled cycles
  task automatic issue(input logic [31:0] ins, output int stalls);
    logic acc;
    stalls = 0;
    acc = 1'b0;
    for (int k = 0; k < 10 && !acc; k++) begin
      step(1'b1, ins, acc);
      if (!acc) stalls++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $error("FAIL accept_timeout observed=not_accepted expected=accepted ins=%0h", ins);
    end
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int k = 0; k < n; k++) step(1'b0, 32'h0, acc);
  endtask

  task automatic reset_mid_cycle();
    #3;
    instr_valid = 1'b0;
    rst = 1'b1;
    #1;
    model_reset();
    check("rst_instr_ready", 64'(instr_ready), 64'd1);
    check_outputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    logic acc;
    logic [31:0] pend;
    logic pend_v;
    rst = 1'b1;
    instr_valid = 1'b0;
    instruction = 32'h0;
    model_reset();
    #1;
    check("reset_instr_ready", 64'(instr_ready), 64'd1);
    check_outputs();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // LW r3 then ADD r5 = r3 + r4
    idle(1);
    issue(enc_i(8, 0, 3), st);
    issue(enc_r(3, 4, 5, 32, 10), st);
    check("lw_add_stalls", 64'(st), 64'd1);
    check("lw_add_alu", 64'(ctrl_ex[ALU_LO+:2]), 64'd0);
    check("lw_add_rd", 64'(ctrl_ex[AW-1:0]), 64'd5);

    // LW r3 then SW storing r3
    idle(1);
    issue(enc_i(8, 0, 3), st);
    issue(enc_i(9, 1, 3), st);
    check("lw_sw_stalls", 64'(st), 64'd1);

    // LW r3 then LW overwriting r3: no source dependency
    idle(1);
    issue(enc_i(8, 0, 3), st);
    issue(enc_i(8, 0, 3), st);
    check("lw_lw_stalls", 64'(st), 64'd0);

    // Back-to-back MUL
    idle(1);
    issue(enc_r(1, 2, 6, 50, 10), st);
    issue(enc_r(1, 2, 7, 50, 10), st);
    check("mul_mul_stalls", 64'(st), 64'(LAT - 1));
    check("mul_hab", 64'(ctrl_ex[HAB_B]), 64'd1);
    check("mul_mao", 64'(ctrl_ex[MAO_B]), 64'd0);

    // Illegal flood saturating the counter
    idle(2);
    for (int i = 0; i < 300; i++) begin
      step(1'b1, enc_i(0, i % 32, (i * 7) % 32), acc);
    end
    check("illegal_sat", 64'(illegal_cnt), 64'd255);
    check("illegal_last_pulse", 64'(illegal), 64'd1);

    // Reset with ADD, SUB, OR in flight
    issue(enc_r(1, 2, 3, 32, 10), st);
    issue(enc_r(4, 5, 6, 34, 10), st);
    issue(enc_r(7, 8, 9, 37, 10), st);
    reset_mid_cycle();
    issue(enc_r(1, 2, 10, 36, 10), st);
    check("post_rst_and_valid", 64'(valid_ex), 64'd1);
    check("post_rst_and_alu", 64'(ctrl_ex[ALU_LO+:2]), 64'd2);

    // Random traffic with small register numbers to provoke hazards
    pend_v = 1'b0;
    pend = 32'h0;
    for (int i = 0; i < 400; i++) begin
      int kind, a, b, c;
      if (i == 200) begin
        reset_mid_cycle();
        pend_v = 1'b0;
      end
      if (!pend_v) begin
        kind = int'($urandom_range(0, 8));
        a = int'($urandom_range(0, 3));
        b = int'($urandom_range(0, 3));
        c = int'($urandom_range(0, 3));
        case (kind)
          0: pend = enc_i(8, a, b);
          1: pend = enc_i(9, a, b);
          2: pend = enc_r(a, b, c, 32, 10);
          3: pend = enc_r(a, b, c, 34, 10);
          4: pend = enc_r(a, b, c, 36, 10);
          5: pend = enc_r(a, b, c, 37, 10);
          6: pend = enc_r(a, b, c, 50, 10);
          7: pend = enc_i(($urandom_range(0, 1) == 0) ? 0 : 63, a, b);
          default: pend = enc_r(a, b, c, 32, 0);
        endcase
        pend_v = ($urandom_range(0, 3) != 0);
      end
      step(pend_v, pend, acc);
      if (acc || !pend_v) pend_v = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
